// File: rtl/sc_game_scheduler_if.sv
// Game scheduler bus: groups the pacing inputs (start, collision, point) and the
// pacing/status outputs (T0 strobe, WAIT hold, level, lives, game over).
//   master : game side, drives the request/event inputs and observes the status.
//   slave  : scheduler side, consumes the inputs and drives the registered status.
interface sc_game_scheduler_if #(
   parameter int unsigned LEVEL_WIDTH = 3
);

   logic                   SC_GAMESCHEDULER_startButton_InLow;
   logic                   SC_GAMESCHEDULER_collision_InHigh;
   logic                   SC_GAMESCHEDULER_pointPulse_InHigh;
   logic                   SC_GAMESCHEDULER_T0_OutLow;
   logic                   SC_GAMESCHEDULER_WAIT_Out;
   logic [LEVEL_WIDTH-1:0] SC_GAMESCHEDULER_level_Out;
   logic [1:0]             SC_GAMESCHEDULER_lives_Out;
   logic                   SC_GAMESCHEDULER_gameOver_Out;

   modport master (
      output SC_GAMESCHEDULER_startButton_InLow,
      output SC_GAMESCHEDULER_collision_InHigh,
      output SC_GAMESCHEDULER_pointPulse_InHigh,
      input  SC_GAMESCHEDULER_T0_OutLow,
      input  SC_GAMESCHEDULER_WAIT_Out,
      input  SC_GAMESCHEDULER_level_Out,
      input  SC_GAMESCHEDULER_lives_Out,
      input  SC_GAMESCHEDULER_gameOver_Out
   );

   modport slave (
      input  SC_GAMESCHEDULER_startButton_InLow,
      input  SC_GAMESCHEDULER_collision_InHigh,
      input  SC_GAMESCHEDULER_pointPulse_InHigh,
      output SC_GAMESCHEDULER_T0_OutLow,
      output SC_GAMESCHEDULER_WAIT_Out,
      output SC_GAMESCHEDULER_level_Out,
      output SC_GAMESCHEDULER_lives_Out,
      output SC_GAMESCHEDULER_gameOver_Out
   );

endinterface

// File: rtl/sc_game_scheduler.sv
// Timing and progression scheduler for the car/point game. Produces the active-low
// move strobe T0 and the WAIT hold, tracks level and lives, shortens the move period
// as points accumulate, pauses after a collision and declares game over.
// Ports:
//   SC_GAMESCHEDULER_CLOCK_50     : system clock
//   SC_GAMESCHEDULER_RESET_InLow  : asynchronous active-low reset
//   schedBus (slave)              : start/collision/point inputs; T0, WAIT, level,
//                                   lives and gameOver registered outputs
module sc_game_scheduler #(
   parameter int unsigned PERIOD_WIDTH     = 24,
   parameter int unsigned BASE_PERIOD      = 5000000,
   parameter int unsigned PERIOD_STEP      = 500000,
   parameter int unsigned MIN_PERIOD       = 1000000,
   parameter int unsigned LEVEL_WIDTH      = 3,
   parameter int unsigned POINTS_PER_LEVEL = 8,
   parameter int unsigned WAIT_TICKS       = 20
) (
   input logic                SC_GAMESCHEDULER_CLOCK_50,
   input logic                SC_GAMESCHEDULER_RESET_InLow,
   sc_game_scheduler_if.slave schedBus
);

   localparam logic [PERIOD_WIDTH-1:0] BasePeriod = PERIOD_WIDTH'(BASE_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] PeriodStep = PERIOD_WIDTH'(PERIOD_STEP);
   localparam logic [PERIOD_WIDTH-1:0] MinPeriod  = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [LEVEL_WIDTH-1:0]  LevelMax   = '1;
   localparam logic [4:0]              PointsLast = 5'(POINTS_PER_LEVEL - 1);
   localparam int unsigned             TickWidth  = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
   localparam logic [TickWidth-1:0]    TicksLast  = TickWidth'(WAIT_TICKS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StOver} stateT;

   stateT                   state_q, state_d;
   logic [PERIOD_WIDTH-1:0] prescaler_q, prescaler_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] targetPeriod_q, targetPeriod_d;
   logic [LEVEL_WIDTH-1:0]  level_q, level_d;
   logic [1:0]              lives_q, lives_d;
   logic [4:0]              pointCnt_q, pointCnt_d;
   logic [TickWidth-1:0]    pauseCnt_q, pauseCnt_d;
   logic                    t0_q, t0_d;
   logic                    waitHold_q, waitHold_d;
   logic                    gameOver_q, gameOver_d;

   logic                    startReq;
   logic                    collision;
   logic                    pointPulse;
   logic                    wrap;
   logic [PERIOD_WIDTH-1:0] prescalerNext;
   logic [PERIOD_WIDTH:0]   floorPlusStep;
   logic [PERIOD_WIDTH-1:0] steppedPeriod;

   assign startReq   = ~schedBus.SC_GAMESCHEDULER_startButton_InLow;
   assign collision  = schedBus.SC_GAMESCHEDULER_collision_InHigh;
   assign pointPulse = schedBus.SC_GAMESCHEDULER_pointPulse_InHigh;

   assign wrap          = (prescaler_q == (period_q - PERIOD_WIDTH'(1)));
   assign prescalerNext = wrap ? '0 : prescaler_q + PERIOD_WIDTH'(1);

   // Extra bit keeps the floor comparison safe from underflow of period-step.
   assign floorPlusStep = {1'b0, MinPeriod} + {1'b0, PeriodStep};
   assign steppedPeriod = ({1'b0, targetPeriod_q} < floorPlusStep) ? MinPeriod
                                                                   : targetPeriod_q - PeriodStep;

   always_comb begin
      state_d        = state_q;
      prescaler_d    = prescaler_q;
      period_d       = period_q;
      targetPeriod_d = targetPeriod_q;
      level_d        = level_q;
      lives_d        = lives_q;
      pointCnt_d     = pointCnt_q;
      pauseCnt_d     = pauseCnt_q;
      t0_d           = 1'b1;
      waitHold_d     = waitHold_q;
      gameOver_d     = gameOver_q;

      unique case (state_q)
         StIdle: begin
            if (startReq) begin
               state_d        = StRun;
               prescaler_d    = '0;
               period_d       = BasePeriod;
               targetPeriod_d = BasePeriod;
               level_d        = '0;
               lives_d        = 2'd3;
               pointCnt_d     = '0;
            end
         end

         StRun: begin
            if (collision) begin
               // Collision wins: same-cycle point and wrap are dropped, no strobe.
               lives_d     = lives_q - 2'd1;
               prescaler_d = '0;
               waitHold_d  = 1'b1;
               if (lives_q == 2'd1) begin
                  state_d    = StOver;
                  gameOver_d = 1'b1;
               end else begin
                  state_d    = StPause;
                  pauseCnt_d = '0;
               end
            end else begin
               prescaler_d = prescalerNext;
               if (pointPulse) begin
                  if (pointCnt_q == PointsLast) begin
                     pointCnt_d     = '0;
                     targetPeriod_d = steppedPeriod;
                     if (level_q != LevelMax) begin
                        level_d = level_q + LEVEL_WIDTH'(1);
                     end
                  end else begin
                     pointCnt_d = pointCnt_q + 5'd1;
                  end
               end
               // A shortened period is only adopted at a wrap so a move never
               // gets cut short mid-interval.
               if (wrap) begin
                  t0_d     = 1'b0;
                  period_d = targetPeriod_d;
               end
            end
         end

         StPause: begin
            prescaler_d = prescalerNext;
            if (wrap) begin
               period_d = targetPeriod_q;
               if (pauseCnt_q == TicksLast) begin
                  state_d    = StRun;
                  waitHold_d = 1'b0;
               end else begin
                  pauseCnt_d = pauseCnt_q + TickWidth'(1);
               end
            end
         end

         StOver: begin
            if (startReq) begin
               state_d        = StIdle;
               prescaler_d    = '0;
               period_d       = BasePeriod;
               targetPeriod_d = BasePeriod;
               level_d        = '0;
               lives_d        = 2'd3;
               pointCnt_d     = '0;
               pauseCnt_d     = '0;
               waitHold_d     = 1'b0;
               gameOver_d     = 1'b0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge SC_GAMESCHEDULER_CLOCK_50 or negedge SC_GAMESCHEDULER_RESET_InLow) begin
      if (!SC_GAMESCHEDULER_RESET_InLow) begin
         state_q        <= StIdle;
         prescaler_q    <= '0;
         period_q       <= BasePeriod;
         targetPeriod_q <= BasePeriod;
         level_q        <= '0;
         lives_q        <= 2'd3;
         pointCnt_q     <= '0;
         pauseCnt_q     <= '0;
         t0_q           <= 1'b1;
         waitHold_q     <= 1'b0;
         gameOver_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         prescaler_q    <= prescaler_d;
         period_q       <= period_d;
         targetPeriod_q <= targetPeriod_d;
         level_q        <= level_d;
         lives_q        <= lives_d;
         pointCnt_q     <= pointCnt_d;
         pauseCnt_q     <= pauseCnt_d;
         t0_q           <= t0_d;
         waitHold_q     <= waitHold_d;
         gameOver_q     <= gameOver_d;
      end
   end

   assign schedBus.SC_GAMESCHEDULER_T0_OutLow    = t0_q;
   assign schedBus.SC_GAMESCHEDULER_WAIT_Out     = waitHold_q;
   assign schedBus.SC_GAMESCHEDULER_level_Out    = level_q;
   assign schedBus.SC_GAMESCHEDULER_lives_Out    = lives_q;
   assign schedBus.SC_GAMESCHEDULER_gameOver_Out = gameOver_q;

endmodule

// File: tb/tb_sc_game_scheduler.sv
// Self-checking bench for sc_game_scheduler: a directed vector table for pacing and
// level progression, hand sequences for pause, game over, simultaneous events and
// async reset, then randomized traffic against a countdown-style reference model.
module tb_sc_game_scheduler;

   localparam int BASE  = 10;
   localparam int STEP  = 2;
   localparam int MINP  = 4;
   localparam int PPL   = 2;
   localparam int WT    = 3;
   localparam int LVMAX = 7;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MPause = 2;
   localparam int MOver  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b1;
   logic col = 1'b0;
   logic pt = 1'b0;

   int nChecks = 0;
   int nFails  = 0;

   sc_game_scheduler_if #(.LEVEL_WIDTH(3)) gameBus ();

   assign gameBus.SC_GAMESCHEDULER_startButton_InLow = start;
   assign gameBus.SC_GAMESCHEDULER_collision_InHigh  = col;
   assign gameBus.SC_GAMESCHEDULER_pointPulse_InHigh = pt;

   sc_game_scheduler #(
      .PERIOD_WIDTH    (24),
      .BASE_PERIOD     (BASE),
      .PERIOD_STEP     (STEP),
      .MIN_PERIOD      (MINP),
      .LEVEL_WIDTH     (3),
      .POINTS_PER_LEVEL(PPL),
      .WAIT_TICKS      (WT)
   ) dut (
      .SC_GAMESCHEDULER_CLOCK_50   (clk),
      .SC_GAMESCHEDULER_RESET_InLow(rst),
      .schedBus                    (gameBus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Packed view {T0, WAIT, level[2:0], lives[1:0], gameOver}.
   function automatic logic [7:0] dutOut();
      return {gameBus.SC_GAMESCHEDULER_T0_OutLow, gameBus.SC_GAMESCHEDULER_WAIT_Out,
              gameBus.SC_GAMESCHEDULER_level_Out, gameBus.SC_GAMESCHEDULER_lives_Out,
              gameBus.SC_GAMESCHEDULER_gameOver_Out};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitHoldLow(input string name, input int limit);
      int k = 0;
      while (gameBus.SC_GAMESCHEDULER_WAIT_Out !== 1'b0 && k < limit) begin
         tick();
         k++;
      end
      check(name, {31'd0, gameBus.SC_GAMESCHEDULER_WAIT_Out}, 32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string      name;
      logic       st;
      logic       cl;
      logic       pp;
      int         n;
      logic [7:0] exp;
   } vecT;

   vecT vecs[$];

   task automatic addVec(input string nm, input logic s, input logic c, input logic p,
                         input int n, input logic t0, input logic w, input int lv,
                         input int li, input logic ov);
      vecT v;
      v.name = nm;
      v.st   = s;
      v.cl   = c;
      v.pp   = p;
      v.n    = n;
      v.exp  = {t0, w, 3'(lv), 2'(li), ov};
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Tracks cycles remaining until the next move rather than a prescaler value.
   int   mMode, mLeft, mPer, mPend, mLevel, mLives, mPts, mTicks;
   logic mT0;

   task automatic modelReset();
      mMode  = MIdle;
      mLeft  = BASE;
      mPer   = BASE;
      mPend  = BASE;
      mLevel = 0;
      mLives = 3;
      mPts   = 0;
      mTicks = 0;
      mT0    = 1'b1;
   endtask

   task automatic modelStep(input logic s, input logic c, input logic p);
      mT0 = 1'b1;
      case (mMode)
         MIdle: begin
            if (!s) begin
               modelReset();
               mMode = MRun;
            end
         end
         MRun: begin
            if (c) begin
               mLives = mLives - 1;
               if (mLives == 0) begin
                  mMode = MOver;
               end else begin
                  mMode  = MPause;
                  mLeft  = mPer;
                  mTicks = 0;
               end
            end else begin
               if (p) begin
                  mPts = mPts + 1;
                  if (mPts == PPL) begin
                     mPts = 0;
                     if (mLevel < LVMAX) mLevel = mLevel + 1;
                     mPend = (mPend - STEP < MINP) ? MINP : mPend - STEP;
                  end
               end
               mLeft = mLeft - 1;
               if (mLeft == 0) begin
                  mT0   = 1'b0;
                  mPer  = mPend;
                  mLeft = mPer;
               end
            end
         end
         MPause: begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               mPer   = mPend;
               mLeft  = mPer;
               mTicks = mTicks + 1;
               if (mTicks == WT) mMode = MRun;
            end
         end
         default: begin
            if (!s) modelReset();
         end
      endcase
   endtask

   function automatic logic [7:0] modelOut();
      return {mT0, (mMode == MPause || mMode == MOver), 3'(mLevel), 2'(mLives),
              (mMode == MOver)};
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      // Pacing at period 10, then four level-ups: periods 8, 6, 4, 4.
      addVec("idle_hold",    1, 0, 0, 2,  1, 0, 0, 3, 0);
      addVec("run_entry",    0, 0, 0, 1,  1, 0, 0, 3, 0);
      addVec("c9_no_strobe", 1, 0, 0, 9,  1, 0, 0, 3, 0);
      addVec("c10_strobe",   1, 0, 0, 1,  0, 0, 0, 3, 0);
      addVec("c11_release",  1, 0, 0, 1,  1, 0, 0, 3, 0);
      addVec("c19_no_strobe",1, 0, 0, 8,  1, 0, 0, 3, 0);
      addVec("c20_strobe",   1, 0, 0, 1,  0, 0, 0, 3, 0);
      addVec("c30_strobe",   1, 0, 0, 10, 0, 0, 0, 3, 0);
      addVec("level1",       1, 0, 1, 2,  1, 0, 1, 3, 0);
      addVec("c39_old_per",  1, 0, 0, 7,  1, 0, 1, 3, 0);
      addVec("c40_strobe",   1, 0, 0, 1,  0, 0, 1, 3, 0);
      addVec("c47_p8",       1, 0, 0, 7,  1, 0, 1, 3, 0);
      addVec("c48_p8_strobe",1, 0, 0, 1,  0, 0, 1, 3, 0);
      addVec("level2",       1, 0, 1, 2,  1, 0, 2, 3, 0);
      addVec("c55",          1, 0, 0, 5,  1, 0, 2, 3, 0);
      addVec("c56_strobe",   1, 0, 0, 1,  0, 0, 2, 3, 0);
      addVec("c61_p6",       1, 0, 0, 5,  1, 0, 2, 3, 0);
      addVec("c62_p6_strobe",1, 0, 0, 1,  0, 0, 2, 3, 0);
      addVec("level3",       1, 0, 1, 2,  1, 0, 3, 3, 0);
      addVec("c68_strobe",   1, 0, 0, 4,  0, 0, 3, 3, 0);
      addVec("c71_p4",       1, 0, 0, 3,  1, 0, 3, 3, 0);
      addVec("c72_p4_strobe",1, 0, 0, 1,  0, 0, 3, 3, 0);
      addVec("level4",       1, 0, 1, 2,  1, 0, 4, 3, 0);
      addVec("c76_strobe",   1, 0, 0, 2,  0, 0, 4, 3, 0);
      addVec("c80_floor_p4", 1, 0, 0, 4,  0, 0, 4, 3, 0);

      #12;
      check("reset_values", dutOut(), {1'b1, 1'b0, 3'd0, 2'd3, 1'b0});
      @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (vecs[i]) begin
         start = vecs[i].st;
         col   = vecs[i].cl;
         pt    = vecs[i].pp;
         repeat (vecs[i].n) tick();
         check(vecs[i].name, dutOut(), vecs[i].exp);
      end
      start = 1'b1;
      col   = 1'b0;
      pt    = 1'b0;

      // Collision pause at period 4: 12 held cycles, second collision ignored.
      col = 1'b1;
      tick();
      col = 1'b0;
      check("pause_entry", dutOut(), {1'b1, 1'b1, 3'd4, 2'd2, 1'b0});
      for (int i = 0; i < 11; i++) begin
         col = (i == 3);
         tick();
         check("pause_hold", {30'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow,
                              gameBus.SC_GAMESCHEDULER_WAIT_Out}, 32'd3);
      end
      col = 1'b0;
      tick();
      check("pause_exit", dutOut(), {1'b1, 1'b0, 3'd4, 2'd2, 1'b0});
      repeat (3) tick();
      check("resume_pre", {31'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow}, 32'd1);
      tick();
      check("resume_strobe", {31'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow}, 32'd0);

      // Game over after the remaining two lives, then two-cycle restart.
      col = 1'b1;
      tick();
      col = 1'b0;
      check("lives_1", dutOut(), {1'b1, 1'b1, 3'd4, 2'd1, 1'b0});
      waitHoldLow("pause2_end", 40);
      col = 1'b1;
      tick();
      col = 1'b0;
      check("game_over", dutOut(), {1'b1, 1'b1, 3'd4, 2'd0, 1'b1});
      pt = 1'b1;
      repeat (3) tick();
      pt = 1'b0;
      check("over_hold", dutOut(), {1'b1, 1'b1, 3'd4, 2'd0, 1'b1});
      start = 1'b0;
      tick();
      check("restart_idle", dutOut(), {1'b1, 1'b0, 3'd0, 2'd3, 1'b0});
      tick();
      start = 1'b1;
      check("restart_run", dutOut(), {1'b1, 1'b0, 3'd0, 2'd3, 1'b0});

      // One point, then collision + point on the wrap cycle.
      pt = 1'b1;
      tick();
      pt = 1'b0;
      repeat (8) tick();
      col = 1'b1;
      pt  = 1'b1;
      tick();
      col = 1'b0;
      pt  = 1'b0;
      check("simul_no_strobe", dutOut(), {1'b1, 1'b1, 3'd0, 2'd2, 1'b0});
      waitHoldLow("simul_pause_end", 60);
      pt = 1'b1;
      tick();
      pt = 1'b0;
      check("simul_point_kept", {29'd0, gameBus.SC_GAMESCHEDULER_level_Out}, 32'd1);

      // Async reset in the middle of a pause, between clock edges.
      col = 1'b1;
      tick();
      col = 1'b0;
      check("pause_again", {31'd0, gameBus.SC_GAMESCHEDULER_WAIT_Out}, 32'd1);
      repeat (3) tick();
      #3;
      rst = 1'b0;
      #1;
      check("async_reset", dutOut(), {1'b1, 1'b0, 3'd0, 2'd3, 1'b0});
      #2;
      rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("idle_after_reset", {30'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow,
                                    gameBus.SC_GAMESCHEDULER_WAIT_Out}, 32'd2);
      end
      start = 1'b0;
      tick();
      start = 1'b1;
      repeat (9) tick();
      check("post_reset_c9", {31'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow}, 32'd1);
      tick();
      check("post_reset_strobe", {31'd0, gameBus.SC_GAMESCHEDULER_T0_OutLow}, 32'd0);

      // Randomized traffic against the reference model.
      #2;
      rst = 1'b0;
      modelReset();
      #2;
      rst = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 29) != 0);
         col   = ($urandom_range(0, 59) == 0);
         pt    = ($urandom_range(0, 2) == 0);
         modelStep(start, col, pt);
         tick();
         check("random", dutOut(), modelOut());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
